write_data_pack_fifo: RTL and testbench
=======================================

Name: write_data_pack_fifo

Overview:
- Next-generation write-data buffer between the frontend command path and the DRAM backend.
- Accepts frontend-width write beats, packs RATIO consecutive beats into one backend word, and stores backend words in a parametrised-depth circular buffer.
- Presents stored words first-word-fall-through to the backend scheduler.
- Adds valid/ready handshakes on both sides, an occupancy count and a programmable almost-full flag.

Parameters:
- IN_WIDTH, 256 (FRONTEND_WORD_SIZE): width of one frontend beat.
- RATIO, 4: beats per backend word; power of two, ≥2.
- ADDR_BITS, 4: log2 of storage depth; depth = 2^ADDR_BITS backend words.
- AFULL_THRESH, 12: occupancy (backend words) at or above which o_almost_full asserts; 1..2^ADDR_BITS.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_data  in  IN_WIDTH  frontend write beat.
- i_valid  in  1  beat valid.
- o_ready  out  1  beat accepted when i_valid && o_ready.
- o_data  out  IN_WIDTH*RATIO  head backend word.
- o_valid  out  1  head word valid (= !o_empty).
- i_ready  in  1  backend pops head when o_valid && i_ready.
- o_level  out  ADDR_BITS+1  stored backend words, 0..2^ADDR_BITS.
- o_beat_cnt  out  log2(RATIO)  beats held in the partial assembly.
- o_full  out  1  o_level == 2^ADDR_BITS.
- o_empty  out  1  o_level == 0.
- o_almost_full  out  1  o_level >= AFULL_THRESH.

Behaviour:
- Reset state (sampled on i_clk while i_rst_n=0):
  - Write and read pointers = 0, beat counter = 0, o_level = 0.
  - o_empty = 1, o_valid = 0, o_full = 0, o_almost_full = 0.
  - o_ready = 1 once reset deasserts.
  - Storage and the assembly register are not reset. o_data is don't-care while o_valid = 0.
- Reset asserted mid-burst discards the partial assembly and all stored words.
- Pointers are ADDR_BITS+1 bits. The MSB is the wrap bit; the low bits index storage.
  - Empty: pointers equal.
  - Full: low bits equal and MSBs differ.
  - Pointers wrap naturally from 2^(ADDR_BITS+1)-1 to 0.
- Packing:
  - Accepted beat k (k = o_beat_cnt) lands in bits [k*IN_WIDTH +: IN_WIDTH]; beat 0 is least significant.
  - The beat counter increments on each accepted beat and wraps RATIO-1 → 0.
  - On acceptance of beat RATIO-1, the assembled word (assembly register plus the incoming beat) is written to mem[wr_ptr] on that same edge, and wr_ptr increments.
- o_ready (combinational from registered state) = (o_beat_cnt != RATIO-1) || !o_full.
  - Beats 0..RATIO-2 are always accepted.
  - The final beat stalls while the buffer is full.
  - A pop in the same cycle does not unblock it; there is no full-pass-through.
- Read side is first-word-fall-through: o_data = mem[rd_ptr low bits], combinational. A pop advances rd_ptr by 1.
- Pop while empty is ignored: pointer stable, no underflow.
- Simultaneous push (final beat) and pop when not full: both occur and o_level is unchanged.
- Latency: the last beat accepted at edge N gives o_valid = 1 after edge N (visible in cycle N+1) when the buffer was empty.
- o_empty, o_full, o_almost_full and o_level are registered from the next-pointer values, so they are exact in the cycle after the edge that changed them.

Optional Feature:
- Macro: WDF_FLUSH_EN.
- Defined:
  - Adds input port i_flush (1 bit).
  - i_flush = 1 at an edge returns pointers, beat counter and all flags to their reset values; storage is untouched.
  - Flush overrides any concurrent push or pop in that cycle.
  - Flush is ignored while i_rst_n = 0.
- Undefined: no i_flush port and no flush logic.

Decomposition:
- Package wdf_pkg:
  - FRONTEND_WORD_SIZE = 256 and BACKEND_WORD_SIZE = FRONTEND_WORD_SIZE*4.
  - typedef fe_beat_t (IN_WIDTH) and be_word_t (backend width).
  - Function clog2_ratio for sizing the beat counter.
- Sub-module wdf_packer: beat counter plus assembly register. Outputs the assembled word and a word_done pulse to the storage/pointer logic in the top module.

Test Plan:
- Reset, then 4 beats 0xA0..0xA3 with i_ready = 0 → o_valid rises the cycle after beat 4; o_data lanes 0..3 read 0xA0, 0xA1, 0xA2, 0xA3 (LSB lane first); o_level = 1; o_beat_cnt returns to 0.
- Push 16 words (64 beats), i_ready = 0 → o_almost_full asserts when o_level reaches 12. o_full = 1 at 16. The 64th beat is accepted, then beats 65..67 are accepted (o_beat_cnt = 3) and beat 68 sees o_ready = 0. Draining one word gives o_ready = 1 on the following cycle.
- Continuous streaming of 100 words with i_ready random at 50% → output sequence equals input sequence. Pointers wrap at least 6 times. o_level never exceeds 16, never underflows, and o_valid = 0 whenever o_level = 0.
- i_ready = 1 while empty for 10 cycles → rd_ptr stable, o_level = 0, o_empty stays 1.
- Assert i_rst_n = 0 after 2 beats of a burst with 3 words stored → next cycle o_level = 0, o_empty = 1, o_beat_cnt = 0. The following 4-beat burst yields exactly one word made of the new beats only.
- With WDF_FLUSH_EN defined: i_flush = 1 with 5 stored words and 1 partial beat, concurrent with a pop and a push → o_level = 0, o_beat_cnt = 0, o_empty = 1 next cycle, and the next burst reads back correctly.

Source files
------------

// File: rtl/wdf_pkg.sv
// Shared types and sizing helpers for the write-data pack FIFO.
// FRONTEND_WORD_SIZE / BACKEND_WORD_SIZE describe the native beat and word
// widths; clog2_ratio sizes the beat counter (never narrower than 1 bit).
package wdf_pkg;

  localparam int FRONTEND_WORD_SIZE = 256;
  localparam int BACKEND_WORD_SIZE  = FRONTEND_WORD_SIZE * 4;

  typedef logic [FRONTEND_WORD_SIZE-1:0] fe_beat_t;
  typedef logic [BACKEND_WORD_SIZE-1:0]  be_word_t;

  function automatic int clog2_ratio(input int ratio);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if (int'(32'd1 << i) < ratio) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/wdf_packer.sv
// Beat packer: collects RATIO frontend beats into one backend word.
// Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   i_flush         drops the partial assembly (beat counter back to 0)
//   i_accept        a beat is taken this cycle
//   i_beat          incoming beat
//   o_word          assembled word (assembly register with the incoming beat
//                   merged into the current lane)
//   o_word_done     the final beat of a word is being accepted this cycle
//   o_beat_cnt      beats already held in the assembly register
module wdf_packer import wdf_pkg::*; #(
  parameter  int IN_WIDTH = FRONTEND_WORD_SIZE,
  parameter  int RATIO    = 4,
  localparam int CNT_W    = clog2_ratio(RATIO),
  localparam int WORD_W   = IN_WIDTH * RATIO
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_flush,
  input  logic                i_accept,
  input  logic [IN_WIDTH-1:0] i_beat,
  output logic [WORD_W-1:0]   o_word,
  output logic                o_word_done,
  output logic [CNT_W-1:0]    o_beat_cnt
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]  cnt_r;
  logic [WORD_W-1:0] asm_r;

  // Beat counter; RATIO is a power of two so it wraps naturally.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_r <= '0;
    end else if (i_flush) begin
      cnt_r <= '0;
    end else if (i_accept) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Assembly lanes; contents are meaningless until refilled, so no reset.
  always_ff @(posedge i_clk) begin
    if (i_accept) begin
      asm_r[int'(cnt_r)*IN_WIDTH +: IN_WIDTH] <= i_beat;
    end else begin
      asm_r <= asm_r;
    end
  end

  // The last beat bypasses the register so the word is stored on its own edge.
  always_comb begin
    o_word = asm_r;
    o_word[int'(cnt_r)*IN_WIDTH +: IN_WIDTH] = i_beat;
  end

  assign o_word_done = i_accept && (cnt_r == LAST_BEAT);
  assign o_beat_cnt  = cnt_r;

endmodule

// File: rtl/write_data_pack_fifo.sv
// Write-data buffer: packs RATIO frontend beats into one backend word and
// queues words in a 2^ADDR_BITS deep circular buffer, read first-word-fall-
// through by the backend.
// Ports:
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_data/i_valid/o_ready   frontend beat handshake
//   o_data/o_valid/i_ready   backend word handshake (o_data = head word)
//   o_level                  stored words, 0..2^ADDR_BITS
//   o_beat_cnt               beats held in the partial assembly
//   o_full/o_empty/o_almost_full  occupancy flags
//   i_flush                  only with WDF_FLUSH_EN defined: clears pointers,
//                            beat counter and flags, leaves storage alone
module write_data_pack_fifo import wdf_pkg::*; #(
  parameter int IN_WIDTH     = FRONTEND_WORD_SIZE,
  parameter int RATIO        = 4,
  parameter int ADDR_BITS    = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [IN_WIDTH-1:0]           i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic [IN_WIDTH*RATIO-1:0]     o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [ADDR_BITS:0]            o_level,
  output logic [clog2_ratio(RATIO)-1:0] o_beat_cnt,
  output logic                          o_full,
  output logic                          o_empty,
  output logic                          o_almost_full
`ifdef WDF_FLUSH_EN
  ,
  input  logic                          i_flush
`endif
);

  localparam int CNT_W  = clog2_ratio(RATIO);
  localparam int WORD_W = IN_WIDTH * RATIO;
  localparam int DEPTH  = 1 << ADDR_BITS;
  localparam int PTR_W  = ADDR_BITS + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);
  localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_THRESH);

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r, level_r;
  logic [PTR_W-1:0]  wr_ptr_nxt_s, rd_ptr_nxt_s, level_nxt_s;
  logic              empty_r, full_r, afull_r;
  logic              full_nxt_s;
  logic              flush_s, accept_s, push_s, pop_s;
  logic [WORD_W-1:0] word_s;
  logic [CNT_W-1:0]  beat_cnt_s;

`ifdef WDF_FLUSH_EN
  assign flush_s = i_flush;
`else
  assign flush_s = 1'b0;
`endif

  // Only the final beat can stall: it needs a free slot, and a same-cycle
  // pop does not count as one.
  assign o_ready  = (beat_cnt_s != LAST_BEAT) || !full_r;
  assign accept_s = i_valid && o_ready;
  assign pop_s    = !empty_r && i_ready;

  wdf_packer #(
    .IN_WIDTH (IN_WIDTH),
    .RATIO    (RATIO)
  ) u_packer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (flush_s),
    .i_accept    (accept_s),
    .i_beat      (i_data),
    .o_word      (word_s),
    .o_word_done (push_s),
    .o_beat_cnt  (beat_cnt_s)
  );

  // Next pointers and the flags derived from them; flush beats push/pop.
  always_comb begin
    if (flush_s) begin
      wr_ptr_nxt_s = '0;
      rd_ptr_nxt_s = '0;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r + {{ADDR_BITS{1'b0}}, push_s};
      rd_ptr_nxt_s = rd_ptr_r + {{ADDR_BITS{1'b0}}, pop_s};
    end
    level_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
    full_nxt_s  = (wr_ptr_nxt_s[ADDR_BITS-1:0] == rd_ptr_nxt_s[ADDR_BITS-1:0]) &&
                  (wr_ptr_nxt_s[ADDR_BITS] != rd_ptr_nxt_s[ADDR_BITS]);
  end

  // Pointer and flag registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      afull_r  <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      level_r  <= level_nxt_s;
      empty_r  <= (wr_ptr_nxt_s == rd_ptr_nxt_s);
      full_r   <= full_nxt_s;
      afull_r  <= (level_nxt_s >= AFULL_LVL);
    end
  end

  // Word storage, deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (push_s && i_rst_n && !flush_s) begin
      mem_r[wr_ptr_r[ADDR_BITS-1:0]] <= word_s;
    end
  end

  assign o_data        = mem_r[rd_ptr_r[ADDR_BITS-1:0]];
  assign o_valid       = !empty_r;
  assign o_level       = level_r;
  assign o_beat_cnt    = beat_cnt_s;
  assign o_full        = full_r;
  assign o_empty       = empty_r;
  assign o_almost_full = afull_r;

endmodule

// File: tb/tb_write_data_pack_fifo.sv
// Self-checking bench for write_data_pack_fifo: a directed vector table, then
// model-checked sequences (fill/stall, random streaming, idle pops, mid-burst
// reset and, with WDF_FLUSH_EN, flush). The model is a queue of words plus a
// queue of pending beats.
module tb_write_data_pack_fifo;

  localparam int IN_W  = 256;
  localparam int RATIO = 4;
  localparam int AB    = 4;
  localparam int DEPTH = 16;
  localparam int TH    = 12;
  localparam int BE_W  = IN_W * RATIO;

  logic            clk = 1'b0;
  logic            rst_n, vin, rdy_in, rdy_out, vout, full, empty, afull;
  logic [IN_W-1:0] din;
  logic [BE_W-1:0] dout;
  logic [AB:0]     level;
  logic [1:0]      bcnt;
`ifdef WDF_FLUSH_EN
  logic            flush;
`endif

  always #5 clk = ~clk;

  write_data_pack_fifo #(
    .IN_WIDTH(IN_W), .RATIO(RATIO), .ADDR_BITS(AB), .AFULL_THRESH(TH)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(din), .i_valid(vin), .o_ready(rdy_out),
    .o_data(dout), .o_valid(vout), .i_ready(rdy_in), .o_level(level),
    .o_beat_cnt(bcnt), .o_full(full), .o_empty(empty), .o_almost_full(afull)
`ifdef WDF_FLUSH_EN
    , .i_flush(flush)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;
  logic [BE_W-1:0] mq[$];
  logic [IN_W-1:0] part[$];

  typedef struct {
    logic            v;
    logic [IN_W-1:0] d;
    logic            r;
    logic            e_rdy;
    logic            e_vld;
    int              e_lvl;
    int              e_cnt;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [IN_W-1:0] rand_beat();
    logic [IN_W-1:0] b;
    for (int i = 0; i < IN_W / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // Compare every observable output with the model state.
  task automatic check_model(input string tag);
    logic [BE_W-1:0] head;
    logic [IN_W-1:0] exp_lane, act_lane;
    bit m_rdy;
    m_rdy = !(part.size() == RATIO - 1 && mq.size() == DEPTH);
    chk({tag, " level"}, IN_W'(level), IN_W'(mq.size()));
    chk({tag, " beat_cnt"}, IN_W'(bcnt), IN_W'(part.size()));
    chk({tag, " ready"}, IN_W'(rdy_out), IN_W'(m_rdy));
    chk({tag, " valid"}, IN_W'(vout), IN_W'(mq.size() != 0));
    chk({tag, " empty"}, IN_W'(empty), IN_W'(mq.size() == 0));
    chk({tag, " full"}, IN_W'(full), IN_W'(mq.size() == DEPTH));
    chk({tag, " afull"}, IN_W'(afull), IN_W'(mq.size() >= TH));
    if (mq.size() != 0) begin
      head = mq[0];
      for (int l = 0; l < RATIO; l++) begin
        exp_lane = head[l*IN_W +: IN_W];
        act_lane = dout[l*IN_W +: IN_W];
        chk($sformatf("%s data lane%0d", tag, l), act_lane, exp_lane);
      end
    end
  endtask

  // One clock with the given inputs; the model follows the handshake rules.
  task automatic cycle(input logic v, input logic [IN_W-1:0] d, input logic r,
                       input string tag, output bit acc, output bit pop);
    logic [BE_W-1:0] w;
    bit m_rdy;
    m_rdy = !(part.size() == RATIO - 1 && mq.size() == DEPTH);
    acc = v && m_rdy;
    pop = r && (mq.size() != 0);
    vin = v; din = d; rdy_in = r;
    @(posedge clk);
    if (pop) w = mq.pop_front();
    if (acc) begin
      part.push_back(d);
      if (part.size() == RATIO) begin
        for (int l = 0; l < RATIO; l++) w[l*IN_W +: IN_W] = part[l];
        mq.push_back(w);
        part.delete();
      end
    end
    @(negedge clk);
    vin = 1'b0;
    check_model(tag);
  endtask

  initial begin
    bit a, p;
    int beats_sent, words_out, budget;
    logic [IN_W-1:0] lane;

    rst_n = 1'b0; vin = 1'b0; din = '0; rdy_in = 1'b0;
`ifdef WDF_FLUSH_EN
    flush = 1'b0;
`endif
    @(negedge clk);
    step();
    chk("reset level", IN_W'(level), IN_W'(0));
    chk("reset empty", IN_W'(empty), IN_W'(1));
    chk("reset valid", IN_W'(vout), IN_W'(0));
    chk("reset full", IN_W'(full), IN_W'(0));
    chk("reset afull", IN_W'(afull), IN_W'(0));
    chk("reset beat_cnt", IN_W'(bcnt), IN_W'(0));
    rst_n = 1'b1;
    step();
    chk("post-reset ready", IN_W'(rdy_out), IN_W'(1));

    // Directed vectors: four beats A0..A3 with backend stalled, then one pop.
    tbl[0] = '{1'b1, IN_W'(32'hA0), 1'b0, 1'b1, 1'b0, 0, 1};
    tbl[1] = '{1'b1, IN_W'(32'hA1), 1'b0, 1'b1, 1'b0, 0, 2};
    tbl[2] = '{1'b1, IN_W'(32'hA2), 1'b0, 1'b1, 1'b0, 0, 3};
    tbl[3] = '{1'b1, IN_W'(32'hA3), 1'b0, 1'b1, 1'b1, 1, 0};
    tbl[4] = '{1'b0, IN_W'(32'h00), 1'b1, 1'b1, 1'b0, 0, 0};
    for (int i = 0; i < 5; i++) begin
      vin = tbl[i].v; din = tbl[i].d; rdy_in = tbl[i].r;
      step();
      chk($sformatf("vec%0d ready", i), IN_W'(rdy_out), IN_W'(tbl[i].e_rdy));
      chk($sformatf("vec%0d valid", i), IN_W'(vout), IN_W'(tbl[i].e_vld));
      chk($sformatf("vec%0d level", i), IN_W'(level), IN_W'(tbl[i].e_lvl));
      chk($sformatf("vec%0d beat_cnt", i), IN_W'(bcnt), IN_W'(tbl[i].e_cnt));
      if (i == 3) begin
        for (int l = 0; l < RATIO; l++) begin
          lane = dout[l*IN_W +: IN_W];
          chk($sformatf("vec3 lane%0d", l), lane, IN_W'(32'hA0 + l));
        end
      end
    end
    vin = 1'b0; rdy_in = 1'b0;

    // Fill to full, fill the partial word to 3 beats, stall the 4th beat.
    for (int w = 0; w < DEPTH; w++)
      for (int b = 0; b < RATIO; b++)
        cycle(1'b1, IN_W'(32'h100 + w*RATIO + b), 1'b0, $sformatf("fill w%0d", w), a, p);
    for (int b = 0; b < RATIO - 1; b++)
      cycle(1'b1, IN_W'(32'h200 + b), 1'b0, "partial", a, p);
    chk("stall ready low", IN_W'(rdy_out), IN_W'(0));
    cycle(1'b1, IN_W'(32'h203), 1'b1, "pop during stall", a, p);
    chk("stalled beat rejected", IN_W'(a), IN_W'(0));
    chk("ready after drain", IN_W'(rdy_out), IN_W'(1));
    cycle(1'b1, IN_W'(32'h203), 1'b0, "final beat", a, p);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, "drain", a, p);

    // Random streaming of 100 words.
    beats_sent = 0; words_out = 0; budget = 0;
    while ((beats_sent < 100 * RATIO || mq.size() != 0) && budget < 5000) begin
      cycle((beats_sent < 100 * RATIO) && ($urandom_range(0, 3) != 0), rand_beat(),
            1'($urandom_range(0, 1)), "stream", a, p);
      if (a) beats_sent++;
      if (p) words_out++;
      budget++;
    end
    chk("stream words out", IN_W'(words_out), IN_W'(100));

    // Pops while empty must be ignored.
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, "idle pop", a, p);
    for (int b = 0; b < RATIO; b++) cycle(1'b1, rand_beat(), 1'b0, "after idle", a, p);
    cycle(1'b0, '0, 1'b1, "after idle pop", a, p);

    // Reset in the middle of a burst with three words stored.
    for (int b = 0; b < 3 * RATIO + 2; b++) cycle(1'b1, rand_beat(), 1'b0, "pre-reset", a, p);
    rst_n = 1'b0; vin = 1'b1; din = rand_beat(); rdy_in = 1'b1;
    step();
    mq.delete(); part.delete();
    vin = 1'b0; rdy_in = 1'b0; rst_n = 1'b1;
    check_model("mid-burst reset");
    for (int b = 0; b < RATIO; b++) cycle(1'b1, IN_W'(32'h300 + b), 1'b0, "post-reset burst", a, p);
    chk("post-reset one word", IN_W'(level), IN_W'(1));
    cycle(1'b0, '0, 1'b1, "post-reset pop", a, p);

`ifdef WDF_FLUSH_EN
    // Flush with 5 words and one partial beat, racing a push and a pop.
    for (int b = 0; b < 5 * RATIO + 1; b++) cycle(1'b1, rand_beat(), 1'b0, "pre-flush", a, p);
    flush = 1'b1; vin = 1'b1; din = rand_beat(); rdy_in = 1'b1;
    step();
    mq.delete(); part.delete();
    flush = 1'b0; vin = 1'b0; rdy_in = 1'b0;
    check_model("flush");
    for (int b = 0; b < RATIO; b++) cycle(1'b1, rand_beat(), 1'b0, "post-flush burst", a, p);
    cycle(1'b0, '0, 1'b1, "post-flush pop", a, p);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
